// File: rtl/instr_fetch_ctrl.sv
// Instruction-memory port sequencer: boot-loader write phase, then PC-driven
// fetch into a registered IF stage with stall, redirect and misalignment trap.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0028,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  input  logic [29:0]          load_addr,
  input  logic [31:0]          load_data,
  output logic                 load_ready,
  input  logic                 boot_done,
  output logic [31:0]          imem_addr,
  output logic                 imem_we,
  output logic [31:0]          imem_wdata,
  input  logic [31:0]          imem_rdata,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 if_valid,
  output logic [31:0]          if_instr,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_pc_plus4,
  output logic                 fetch_err,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_FETCH = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t                r_state, w_state;
  logic [31:0]           r_pc, w_pc;
  logic                  r_if_valid, w_if_valid;
  logic [31:0]           r_if_instr, w_if_instr;
  logic [31:0]           r_if_pc, w_if_pc;
  logic [31:0]           r_if_pc_plus4, w_if_pc_plus4;
  logic                  r_fetch_err, w_fetch_err;
  logic [CNT_WIDTH-1:0]  r_fetch_count, w_fetch_count;
  logic                  w_load_mode;
  logic                  w_misaligned;

  // The loader owns the port while reset is held so the image can be written early.
  assign w_load_mode  = reset || (r_state == S_LOAD);
  assign w_misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

  assign load_ready  = w_load_mode;
  assign imem_we     = w_load_mode && load_valid;
  assign imem_wdata  = w_load_mode ? load_data : 32'h0;
  assign imem_addr   = w_load_mode ? {load_addr, 2'b00} : r_pc;

  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign fetch_err   = r_fetch_err;
  assign fetch_count = r_fetch_count;

  always_comb begin
    // NOTE: every next-state signal defaults to its register so no path infers a latch.
    w_state       = r_state;
    w_pc          = r_pc;
    w_if_valid    = r_if_valid;
    w_if_instr    = r_if_instr;
    w_if_pc       = r_if_pc;
    w_if_pc_plus4 = r_if_pc_plus4;
    w_fetch_err   = r_fetch_err;
    w_fetch_count = r_fetch_count;

    case (r_state)
      S_LOAD: begin
        w_if_valid = 1'b0;
        if (boot_done) begin
          w_pc    = RESET_PC;
          w_state = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_misaligned) begin
          w_state     = S_ERROR;
          w_fetch_err = 1'b1;
          w_if_valid  = 1'b0;
        end else if (redirect_valid) begin
          w_pc       = redirect_pc;
          w_if_valid = 1'b0;
        end else if (!stall) begin
          w_if_instr    = imem_rdata;
          w_if_pc       = r_pc;
          w_if_pc_plus4 = r_pc + 32'd4;
          w_if_valid    = 1'b1;
          w_pc          = r_pc + 32'd4;
          w_fetch_count = r_fetch_count + CNT_WIDTH'(1);
        end
      end
      S_ERROR: begin
        w_if_valid = 1'b0;
      end
      default: begin
        w_state    = S_LOAD;
        w_if_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    if (reset) begin
      r_state       <= S_LOAD;
      r_pc          <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= 32'h0;
      r_if_pc       <= 32'h0;
      r_if_pc_plus4 <= 32'h0;
      r_fetch_err   <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_state       <= w_state;
      r_pc          <= w_pc;
      r_if_valid    <= w_if_valid;
      r_if_instr    <= w_if_instr;
      r_if_pc       <= w_if_pc;
      r_if_pc_plus4 <= w_if_pc_plus4;
      r_fetch_err   <= w_fetch_err;
      r_fetch_count <= w_fetch_count;
    end
  end

endmodule
